// File: rtl/fp_nextafter128_arb.sv
// Arbiter and in-flight ID tracker in front of a shared 2-stage 128-bit nextafter unit.
// Define FPNXT_ARB_RR_EN for round-robin grant; the default is fixed priority (lowest index wins).
module fp_nextafter128_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*128-1:0]    req_a,
  input  logic [NREQ*128-1:0]    req_b,
  output logic                   fu_ce,
  output logic [127:0]           fu_a,
  output logic [127:0]           fu_b,
  input  logic [127:0]           fu_o,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic [127:0]           res_o,
  output logic [1:0]             inflight
);

  logic [LAT-1:0] v_q, v_d;
  logic [IDW-1:0] id_q [LAT];
  logic [IDW-1:0] id_d [LAT];

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_en;

`ifdef FPNXT_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps, so the last winner drops to lowest priority.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_en) ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    int cnt;
    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    fu_ce     = rst | ~v_q[LAT-1] | res_ready;
    gnt_en    = fu_ce & ~rst & gnt_found;
    req_ready = '0;
    fu_a      = '0;
    fu_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_en && gnt_idx == IDW'(i)) begin
        req_ready[i] = 1'b1;
        fu_a         = req_a[128*i +: 128];
        fu_b         = req_b[128*i +: 128];
      end
    end

    // Tracking advances only with the unit's clock enable so IDs stay aligned with data.
    v_d  = v_q;
    id_d = id_q;
    if (fu_ce) begin
      v_d[0]  = gnt_en;
      id_d[0] = gnt_en ? gnt_idx : id_q[0];
      for (int i = 1; i < LAT; i++) begin
        v_d[i]  = v_q[i-1];
        id_d[i] = id_q[i-1];
      end
    end

    cnt = 0;
    for (int i = 0; i < LAT; i++) cnt = cnt + int'(v_q[i]);
    inflight = 2'(cnt);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) id_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < LAT; i++) id_q[i] <= id_d[i];
    end
  end

  assign res_valid = v_q[LAT-1];
  assign res_id    = id_q[LAT-1];
  assign res_o     = fu_o;

endmodule

// File: tb/tb_fp_nextafter128_arb.sv
// Bench for fp_nextafter128_arb: behavioural 2-stage nextafter unit, directed stimulus,
// scoreboard queue filled on grant and drained by an independent result monitor.
module tb_fp_nextafter128_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  localparam logic [127:0] ONE    = 128'h3FFF0000_00000000_00000000_00000000;
  localparam logic [127:0] TWO    = 128'h40000000_00000000_00000000_00000000;
  localparam logic [127:0] MONE   = 128'hBFFF0000_00000000_00000000_00000000;
  localparam logic [127:0] ZERO   = 128'h0;
  localparam logic [127:0] PINF   = 128'h7FFF0000_00000000_00000000_00000000;
  localparam logic [127:0] MAXF   = 128'h7FFEFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] QNAN   = 128'h7FFF8000_00000000_00000000_00000000;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_a, req_b;
  logic                fu_ce;
  logic [127:0]        fu_a, fu_b, fu_o;
  logic                res_valid, res_ready;
  logic [IDW-1:0]      res_id;
  logic [127:0]        res_o;
  logic [1:0]          inflight;

  fp_nextafter128_arb #(.NREQ(NREQ), .IDW(IDW), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .fu_ce(fu_ce), .fu_a(fu_a), .fu_b(fu_b), .fu_o(fu_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_o(res_o),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Reference nextafter for binary128, used only as the shared unit's behaviour.
  function automatic logic [127:0] fkey(input logic [127:0] x);
    return x[127] ? ~x : {1'b1, x[126:0]};
  endfunction

  function automatic logic [127:0] nextafter(input logic [127:0] a, input logic [127:0] b);
    logic a_nan, b_nan, up;
    a_nan = (a[126:112] == 15'h7FFF) && (a[111:0] != 0);
    b_nan = (b[126:112] == 15'h7FFF) && (b[111:0] != 0);
    if (a_nan) return a;
    if (b_nan) return b;
    if (a == b) return b;
    if (a[126:0] == 0 && b[126:0] == 0) return b;
    if (a[126:0] == 0) return {b[127], 127'd1};
    up = (fkey(b) > fkey(a)) ^ a[127];
    return up ? a + 128'd1 : a - 128'd1;
  endfunction

  logic [127:0] s1_q, s2_q;
  always @(posedge clk) begin
    if (fu_ce) begin
      s1_q <= nextafter(fu_a, fu_b);
      s2_q <= s1_q;
    end
  end
  assign fu_o = s2_q;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [127:0]   val;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d value %h with nothing expected", res_id, res_o);
        end else begin
          e = sb.pop_front();
          check("res_id", 128'(res_id), 128'(e.id));
          check("res_o", res_o, e.val);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [127:0] a, input logic [127:0] b);
    req_valid[id]        = 1'b1;
    req_a[128*id +: 128] = a;
    req_b[128*id +: 128] = b;
  endtask

  task automatic idle();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  // Presents one op from a single requester and waits (bounded) for its grant.
  task automatic issue(input int id, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] exp);
    bit got;
    got = 1'b0;
    req_valid = '0;
    set_req(id, a, b);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        sb.push_back('{id: IDW'(id), val: exp});
      end
      @(posedge clk); #1;
    end
    check("grant_wait", 128'(got), 128'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    int           n, pc, exp_g, g;
    int           cnt [NREQ];
    logic [127:0] cur_exp [NREQ];
    logic [111:0] m;

    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;

    // Reset state, with requesters asserting valid to prove no grant leaks out.
    @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_fu_ce", 128'(fu_ce), 128'd1);
    check("rst_res_valid", 128'(res_valid), 128'd0);
    check("rst_inflight", 128'(inflight), 128'd0);
    check("rst_res_id", 128'(res_id), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst = 1'b0;

    // Single op: 1.0 toward 2.0 from requester 1, two-edge latency.
    issue(1, ONE, TWO, 128'h3FFF0000_00000000_00000000_00000001);
    idle();
    @(negedge clk);
    check("lat_early_valid", 128'(res_valid), 128'd0);
    check("lat_inflight1", 128'(inflight), 128'd1);
    @(negedge clk);
    check("lat_valid", 128'(res_valid), 128'd1);
    check("lat_id", 128'(res_id), 128'd1);
    check("lat_val", res_o, 128'h3FFF0000_00000000_00000000_00000001);
    drain();

    // Back-to-back from requester 0, covering round-down, equal, overflow and zero cases.
    issue(0, ONE, ZERO, 128'h3FFEFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    issue(0, TWO, TWO, TWO);
    issue(0, MAXF, PINF, PINF);
    check("b2b_inflight", 128'(inflight), 128'd2);
    issue(0, ZERO, MONE, 128'h80000000_00000000_00000000_00000001);
    idle();
    drain();
    n = pop_cyc.size();
    check("b2b_spacing", 128'(pop_cyc[n-1] - pop_cyc[n-4]), 128'd3);

    // Stall with two in flight while another requester waits.
    issue(0, MONE, ZERO, 128'hBFFEFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    issue(3, ONE, ZERO, 128'h3FFEFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    res_ready = 1'b0;
    req_valid = '0;
    set_req(1, TWO, ONE);
    repeat (5) begin
      @(negedge clk);
      check("stall_fu_ce", 128'(fu_ce), 128'd0);
      check("stall_req_ready", 128'(req_ready), 128'd0);
      check("stall_res_id", 128'(res_id), 128'd0);
      check("stall_res_o", res_o, 128'hBFFEFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
      check("stall_inflight", 128'(inflight), 128'd2);
    end
    @(posedge clk); #1;
    idle();
    res_ready = 1'b1;
    pc = pop_cyc.size();
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("stall_release_count", 128'(pop_cyc.size() - pc), 128'd2);
    @(negedge clk);
    check("stall_no_dup", 128'(res_valid), 128'd0);
    drain();

    // Contention: all four requesters valid for eight grants.
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) begin
      cnt[r]     = 0;
      m          = 112'(16 * r + 1);
      cur_exp[r] = {16'h3FFF, m + 112'd1};
      set_req(r, {16'h3FFF, m}, TWO);
    end
    for (int k = 0; k < 8; k++) begin
`ifdef FPNXT_ARB_RR_EN
      exp_g = k % NREQ;
`else
      exp_g = 0;
`endif
      @(negedge clk);
      check("contention_grant", 128'(req_ready), 128'(4'b0001 << exp_g));
      g = -1;
      for (int r = 0; r < NREQ; r++) if (req_ready[r]) g = r;
      if (g >= 0) sb.push_back('{id: IDW'(g), val: cur_exp[g]});
      @(posedge clk); #1;
      if (g >= 0) begin
        cnt[g]++;
        m          = 112'(16 * g + cnt[g] + 1);
        cur_exp[g] = {16'h3FFF, m + 112'd1};
        set_req(g, {16'h3FFF, m}, TWO);
      end
    end
    idle();
    drain();

    // Reset with two in flight; pointer must return to 0 and nothing stale may surface.
    issue(1, TWO, ONE, 128'h3FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    issue(1, ONE, TWO, 128'h3FFF0000_00000000_00000000_00000001);
    check("pre_rst_inflight", 128'(inflight), 128'd2);
    rst       = 1'b1;
    res_ready = 1'b0;
    for (int r = 0; r < NREQ; r++) set_req(r, ONE, TWO);
    @(negedge clk);
    check("midrst_fu_ce", 128'(fu_ce), 128'd1);
    check("midrst_req_ready", 128'(req_ready), 128'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    sb.delete();
    check("postrst_res_valid", 128'(res_valid), 128'd0);
    check("postrst_inflight", 128'(inflight), 128'd0);
    @(negedge clk);
    check("postrst_first_grant", 128'(req_ready), 128'd1);
    if (req_ready[0]) sb.push_back('{id: IDW'(0), val: 128'h3FFF0000_00000000_00000000_00000001});
    @(posedge clk); #1;
    idle();
    drain();
    repeat (3) begin
      @(negedge clk);
      check("postrst_quiet", 128'(res_valid), 128'd0);
    end

    // NaN passes through the unit untouched, tagged with requester 2.
    @(posedge clk); #1;
    issue(2, QNAN, TWO, QNAN);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
